// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the MIPS core. Owns the PC, issues requests to
//   instruction memory with a hold-until-valid handshake, and holds the IF/ID
//   register. A one-word hold buffer catches a response that lands while
//   decode is stalled. A drain state swallows the in-flight word after a
//   redirect that arrived before its response.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   stall_i                        downstream hazard: hold IF/ID and PC
//   branch_i / branch_tgt_i        taken branch and its target
//   jump_i   / jump_tgt_i          jump and its target (wins over branch)
//   imem_req_o / imem_addr_o       fetch request and address
//   imem_valid_i / imem_rdata_i    memory response and instruction word
//   instr_o, opcode_o              IF/ID instruction and its opcode field
//   pc_plus4_o, valid_o            IF/ID PC+4 and real-instruction flag
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_tgt_i,
   input  logic        jump_i,
   input  logic [31:0] jump_tgt_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [5:0]  opcode_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic [31:0] buf_q, buf_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic [31:0] tgt_raw;
   logic [31:0] tgt;
   logic [31:0] seq_pc;

   always_comb begin
      redirect   = jump_i | branch_i;
      tgt_raw    = jump_i ? jump_tgt_i : branch_tgt_i;
      // Targets are word-aligned; low two bits are ignored.
      tgt        = tgt_raw & 32'hFFFF_FFFC;
      seq_pc     = req_addr_q + 32'd4;

      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      buf_d      = buf_q;
      valid_d    = valid_q;

      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               pc_d    = tgt;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               // A response in this same cycle closes the handshake, so the
               // new target can be requested at once; otherwise the
               // outstanding request must be drained first.
               if (imem_valid_i) begin
                  req_addr_d = tgt;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (imem_valid_i) begin
               pc_d       = seq_pc;
               req_addr_d = seq_pc;
               if (stall_i) begin
                  buf_d   = imem_rdata_i;
                  state_d = S_HOLD;
               end else begin
                  instr_d    = imem_rdata_i;
                  pc_plus4_d = seq_pc;
                  valid_d    = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d       = tgt;
               req_addr_d = tgt;
               instr_d    = NOP_INSTR;
               valid_d    = 1'b0;
               state_d    = S_FETCH;
            end else if (!stall_i) begin
               // pc already equals the buffered word's PC+4.
               instr_d    = buf_q;
               pc_plus4_d = pc_q;
               valid_d    = 1'b1;
               req_addr_d = pc_q;
               state_d    = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (redirect) begin
               pc_d    = tgt;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
            if (imem_valid_i) begin
               req_addr_d = redirect ? tgt : pc_q;
               state_d    = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= RESET_PC;
         buf_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         buf_q      <= buf_d;
         valid_q    <= valid_d;
      end
   end

   // Request is gated by reset so it drops immediately on assertion.
   assign imem_req_o  = rst_n & (state_q != S_HOLD);
   assign imem_addr_o = req_addr_q;
   assign instr_o     = instr_q;
   assign opcode_o    = instr_q[31:26];
   assign pc_plus4_o  = pc_plus4_q;
   assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A transaction-level model predicts the
//   request and the IF/ID contents; the bench also acts as instruction memory
//   with a programmable number of wait states, returning (address ^ mem_xor).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0020;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        branch_i;
   logic [31:0] branch_tgt_i;
   logic        jump_i;
   logic [31:0] jump_tgt_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic [5:0]  opcode_o;
   logic [31:0] pc_plus4_o;
   logic        valid_o;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .branch_i     (branch_i),
      .branch_tgt_i (branch_tgt_i),
      .jump_i       (jump_i),
      .jump_tgt_i   (jump_tgt_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_valid_i (imem_valid_i),
      .imem_rdata_i (imem_rdata_i),
      .instr_o      (instr_o),
      .opcode_o     (opcode_o),
      .pc_plus4_o   (pc_plus4_o),
      .valid_o      (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [31:0] m_pc       = RST_PC;
   logic [31:0] m_req_addr = RST_PC;
   logic [31:0] m_instr    = NOP;
   logic [31:0] m_pc4      = RST_PC;
   logic        m_valid    = 1'b0;
   logic        m_req      = 1'b1;
   logic        m_discard  = 1'b0;   // outstanding word must be thrown away
   logic [31:0] held[$];             // word waiting for decode to un-stall
   int          mem_wait    = 0;     // cycles the current request has waited
   int          wait_states = 0;
   logic [31:0] mem_xor     = 32'h0;

   // Memory responds to the request the model says must be outstanding.
   assign imem_valid_i = rst_n && m_req && (mem_wait >= wait_states);
   assign imem_rdata_i = m_req_addr ^ mem_xor;

   task automatic bubble();
      m_instr = NOP;
      m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic        redirect;
      logic [31:0] tgt;
      logic [31:0] rd;
      logic        acc;
      logic [31:0] nxt;
      if (!rst_n) begin
         m_pc = RST_PC; m_req_addr = RST_PC; m_instr = NOP; m_pc4 = RST_PC;
         m_valid = 1'b0; m_discard = 1'b0; m_req = 1'b1; mem_wait = 0;
         held.delete();
         return;
      end
      redirect = jump_i | branch_i;
      tgt      = (jump_i ? jump_tgt_i : branch_tgt_i) & ~32'h3;
      rd       = m_req_addr ^ mem_xor;
      acc      = m_req && (mem_wait >= wait_states);
      if (held.size() != 0) begin
         if (redirect) begin
            held.delete(); m_pc = tgt; m_req_addr = tgt; bubble();
         end else if (!stall_i) begin
            m_instr = held.pop_front(); m_pc4 = m_pc; m_valid = 1'b1;
            m_req_addr = m_pc;
         end
      end else if (m_discard) begin
         if (redirect) begin
            m_pc = tgt; bubble();
         end
         if (acc) begin
            m_discard = 1'b0; m_req_addr = m_pc;
         end
      end else begin
         if (redirect) begin
            m_pc = tgt; bubble();
            if (acc) m_req_addr = tgt;
            else     m_discard = 1'b1;
         end else if (acc) begin
            nxt = m_req_addr + 32'd4;
            m_pc = nxt; m_req_addr = nxt;
            if (stall_i) held.push_back(rd);
            else begin
               m_instr = rd; m_pc4 = nxt; m_valid = 1'b1;
            end
         end
      end
      m_req = (held.size() == 0);
      if (acc || !m_req) mem_wait = 0;
      else               mem_wait++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         model_step();
      end
   end

   // ---------------- compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req",   32'(imem_req_o), 32'd0);
         chk("rst_addr",  imem_addr_o,     RST_PC);
         chk("rst_instr", instr_o,         NOP);
         chk("rst_pc4",   pc_plus4_o,      RST_PC);
         chk("rst_valid", 32'(valid_o),    32'd0);
      end else begin
         chk("req",    32'(imem_req_o), 32'(m_req));
         if (m_req) chk("addr", imem_addr_o, m_req_addr);
         chk("instr",  instr_o,         m_instr);
         chk("opcode", 32'(opcode_o),   32'(m_instr[31:26]));
         chk("pc4",    pc_plus4_o,      m_pc4);
         chk("valid",  32'(valid_o),    32'(m_valid));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic lit_req(input string n, input logic r, input logic [31:0] a);
      chk({n, "_req"}, 32'(imem_req_o), 32'(r));
      if (r) chk({n, "_addr"}, imem_addr_o, a);
   endtask

   task automatic lit_ifid(input string n, input logic [31:0] i, input logic [31:0] p, input logic v);
      chk({n, "_instr"}, instr_o,      i);
      chk({n, "_pc4"},   pc_plus4_o,   p);
      chk({n, "_valid"}, 32'(valid_o), 32'(v));
   endtask

   task automatic lit_reset(input string n);
      #1;
      lit_req(n, 1'b0, RST_PC);
      chk({n, "_addr"}, imem_addr_o, RST_PC);
      lit_ifid(n, NOP, RST_PC, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
      branch_tgt_i = '0; jump_tgt_i = '0;
      step(); step();
      lit_reset("t0");

      // 1: zero-wait memory, addr-as-data
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         lit_req("t1", 1'b1, 32'(4 * k));
         lit_ifid("t1", 32'(4 * (k - 1)), 32'(4 * k), 1'b1);
      end

      // 4: branch to 0x40 while request to 0x10 waits
      wait_states = 3; branch_i = 1'b1; branch_tgt_i = 32'h40;
      step();
      lit_req("t4", 1'b1, 32'h10);
      lit_ifid("t4", NOP, 32'h10, 1'b0);
      branch_i = 1'b0;
      step(); lit_req("t4d", 1'b1, 32'h10);
      step(); lit_req("t4d", 1'b1, 32'h10);
      step(); lit_req("t4n", 1'b1, 32'h40);
      lit_ifid("t4n", NOP, 32'h10, 1'b0);

      // 2: three wait states, address held four cycles
      for (int k = 0; k < 3; k++) begin
         step(); lit_req("t2a", 1'b1, 32'h40);
      end
      step(); lit_req("t2a", 1'b1, 32'h44);
      lit_ifid("t2a", 32'h40, 32'h44, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(); lit_req("t2b", 1'b1, 32'h44);
         lit_ifid("t2b", 32'h40, 32'h44, 1'b1);
      end
      step(); lit_req("t2b", 1'b1, 32'h48);
      lit_ifid("t2b", 32'h44, 32'h48, 1'b1);

      // 3: stall for three cycles as the 0x48 response arrives
      wait_states = 0; stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(); lit_req("t3", 1'b0, 32'h0);
         lit_ifid("t3", 32'h44, 32'h48, 1'b1);
      end
      stall_i = 1'b0;
      step(); lit_req("t3r", 1'b1, 32'h4C);
      lit_ifid("t3r", 32'h48, 32'h4C, 1'b1);
      step(); lit_ifid("t3n", 32'h4C, 32'h50, 1'b1);

      // redirect while holding a buffered word
      stall_i = 1'b1;
      step(); lit_req("th", 1'b0, 32'h0);
      branch_i = 1'b1; branch_tgt_i = 32'h100;
      step(); lit_req("th", 1'b1, 32'h100);
      lit_ifid("th", NOP, 32'h50, 1'b0);
      branch_i = 1'b0; stall_i = 1'b0;
      step(); lit_ifid("thn", 32'h100, 32'h104, 1'b1);

      // 5: jump + branch + stall together, misaligned jump target
      jump_i = 1'b1; jump_tgt_i = 32'h83; branch_i = 1'b1; branch_tgt_i = 32'h40;
      stall_i = 1'b1;
      step(); lit_req("t5", 1'b1, 32'h80);
      lit_ifid("t5", NOP, 32'h104, 1'b0);
      jump_i = 1'b0; branch_i = 1'b0; stall_i = 1'b0;
      step(); lit_req("t5n", 1'b1, 32'h84);
      lit_ifid("t5n", 32'h80, 32'h84, 1'b1);

      // 6: reset mid-wait
      mem_xor = 32'h8C00_0000; wait_states = 3;
      step(); lit_req("t6w", 1'b1, 32'h84);
      rst_n = 1'b0;
      lit_reset("t6w");
      step();
      rst_n = 1'b1; wait_states = 0;
      step(); lit_req("t6a", 1'b1, 32'h4);
      lit_ifid("t6a", 32'h8C00_0000, 32'h4, 1'b1);
      chk("t6a_opcode", 32'(opcode_o), 32'h23);

      // 6: reset mid-HOLD
      stall_i = 1'b1;
      step(); lit_req("t6h", 1'b0, 32'h0);
      rst_n = 1'b0;
      lit_reset("t6h");
      step();
      rst_n = 1'b1; stall_i = 1'b0;
      step(); lit_req("t6b", 1'b1, 32'h4);
      lit_ifid("t6b", 32'h8C00_0000, 32'h4, 1'b1);

      // PC wrap at 0xFFFFFFFC
      jump_i = 1'b1; jump_tgt_i = 32'hFFFF_FFFC;
      step(); lit_req("tw", 1'b1, 32'hFFFF_FFFC);
      lit_ifid("tw", NOP, 32'h4, 1'b0);
      jump_i = 1'b0;
      step(); lit_req("tw1", 1'b1, 32'h0);
      lit_ifid("tw1", 32'h73FF_FFFC, 32'h0, 1'b1);
      step(); lit_req("tw2", 1'b1, 32'h4);
      lit_ifid("tw2", 32'h8C00_0000, 32'h4, 1'b1);

      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
